// File: rtl/encoder_proj.sv
// Hamming(7,4) serial encoder: a 4-entry nibble FIFO feeds a UART-like framer
// (one start bit, seven code bits LSB first, one stop bit).
module encoder_proj #(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [3:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       tx,
    output logic       busy,
    output logic [6:0] code_out,
    output logic       frame_done,
    output logic [2:0] fifo_count
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam logic [7:0] BIT_LAST = 8'(CLKS_PER_BIT - 1);

    state_t     state, state_n;
    logic [7:0] cnt, cnt_n;
    logic [2:0] idx, idx_n;
    logic [6:0] shreg, shreg_n, code_n;
    logic       tx_n, busy_n, done_n;
    logic       push, pop;

    logic [3:0] mem [4];
    logic [1:0] wr_ptr, rd_ptr;
    logic [2:0] count;

    function automatic logic [6:0] hamming(input logic [3:0] d);
        logic p1, p2, p3;
        p1 = d[0] ^ d[1] ^ d[3];
        p2 = d[0] ^ d[2] ^ d[3];
        p3 = d[1] ^ d[2] ^ d[3];
        return {d[3], d[2], d[1], p3, d[0], p2, p1};
    endfunction

    assign fifo_count = count;
    assign in_ready   = (count != 3'd4);
    assign push       = in_valid & in_ready;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        shreg_n = shreg;
        code_n  = code_out;
        pop     = 1'b0;
        case (state)
            IDLE: pop = (count != 3'd0);
            START: begin
                if (cnt == 8'd0) begin
                    state_n = DATA;
                    cnt_n   = BIT_LAST;
                    idx_n   = '0;
                end else begin
                    cnt_n = cnt - 8'd1;
                end
            end
            DATA: begin
                if (cnt == 8'd0) begin
                    cnt_n = BIT_LAST;
                    if (idx == 3'd6) begin
                        state_n = STOP;
                    end else begin
                        idx_n   = idx + 3'd1;
                        shreg_n = {1'b0, shreg[6:1]};
                    end
                end else begin
                    cnt_n = cnt - 8'd1;
                end
            end
            STOP: begin
                if (cnt == 8'd0) begin
                    if (count != 3'd0) pop = 1'b1;
                    else               state_n = IDLE;
                end else begin
                    cnt_n = cnt - 8'd1;
                end
            end
            default: state_n = IDLE;
        endcase

        // A pop from IDLE or from the last stop cycle both start a fresh frame.
        if (pop) begin
            code_n  = hamming(mem[rd_ptr]);
            shreg_n = code_n;
            state_n = START;
            cnt_n   = BIT_LAST;
        end

        if (state_n == START)     tx_n = 1'b0;
        else if (state_n == DATA) tx_n = shreg_n[0];
        else                      tx_n = 1'b1;
        busy_n = (state_n != IDLE);
        // Registered from next-state so the pulse lines up with the final stop cycle.
        done_n = (state_n == STOP) && (cnt_n == 8'd0);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            shreg      <= '0;
            code_out   <= '0;
            tx         <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            idx        <= idx_n;
            shreg      <= shreg_n;
            code_out   <= code_n;
            tx         <= tx_n;
            busy       <= busy_n;
            frame_done <= done_n;
            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= wr_ptr + 2'd1;
            end
            if (pop) rd_ptr <= rd_ptr + 2'd1;
            count <= count + {2'b00, push} - {2'b00, pop};
        end
    end

endmodule
